// File: rtl/or1200_cypherdb_secwin_if.sv
// Bus bundle for the CypherDB secure-window tracker.
//   master: decode side, drives ce/start_pulse/end_pulse/tmo_en/tmo_limit/err_clr,
//           observes secure_exec/secure_any/active_id/nest_depth/err_*.
//   slave : the tracker itself.
interface or1200_cypherdb_secwin_if #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned DEPTH_W = 3,
  parameter int unsigned TMO_W   = 16
);
  localparam int unsigned ID_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic                     ce;
  logic [NCH-1:0]           start_pulse;
  logic [NCH-1:0]           end_pulse;
  logic                     tmo_en;
  logic [TMO_W-1:0]         tmo_limit;
  logic [NCH-1:0]           err_clr;

  logic [NCH-1:0]           secure_exec;
  logic                     secure_any;
  logic [ID_W-1:0]          active_id;
  logic [NCH*DEPTH_W-1:0]   nest_depth;
  logic [NCH-1:0]           err_ovf;
  logic [NCH-1:0]           err_unf;
  logic [NCH-1:0]           err_tmo;
  logic [NCH-1:0]           err_cfl;

  modport master (
    output ce, start_pulse, end_pulse, tmo_en, tmo_limit, err_clr,
    input  secure_exec, secure_any, active_id, nest_depth,
           err_ovf, err_unf, err_tmo, err_cfl
  );

  modport slave (
    input  ce, start_pulse, end_pulse, tmo_en, tmo_limit, err_clr,
    output secure_exec, secure_any, active_id, nest_depth,
           err_ovf, err_unf, err_tmo, err_cfl
  );
endinterface

// File: rtl/or1200_cypherdb_secwin.sv
// Multi-channel secure-execution window tracker. Each channel turns start/end
// pulses into a secure_exec level, with nesting depth, a watchdog, optional
// cross-channel exclusion and sticky per-channel error flags.
// Ports:
//   clk  - core clock
//   rst  - asynchronous reset, active-low
//   bus  - slave side of or1200_cypherdb_secwin_if (control in, window/status out)
module or1200_cypherdb_secwin #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned DEPTH_W = 3,
  parameter int unsigned TMO_W   = 16,
  parameter bit          EXCL    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  or1200_cypherdb_secwin_if.slave bus
);

  localparam int unsigned ID_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FAULT  = 2'd2
  } state_e;

  state_e             state_q [NCH];
  state_e             state_d [NCH];
  logic [DEPTH_W-1:0] depth_q [NCH];
  logic [DEPTH_W-1:0] depth_d [NCH];
  logic [TMO_W-1:0]   wdog_q  [NCH];
  logic [TMO_W-1:0]   wdog_d  [NCH];
  logic [NCH-1:0]     ovf_q, unf_q, tmo_q, cfl_q;
  logic [NCH-1:0]     ovf_d, unf_d, tmo_d, cfl_d;
  logic [NCH-1:0]     accept_c, reject_c, exec_c;
  logic               tmo_on_c;

  assign tmo_on_c = bus.tmo_en && (bus.tmo_limit != '0);

  // Start arbitration: a start from IDLE is blocked by any ACTIVE channel or a
  // lower-index start accepted in the same cycle (only when exclusion is on).
  always_comb begin : p_accept
    logic taken;
    taken    = 1'b0;
    accept_c = '0;
    reject_c = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (state_q[i] == ACTIVE) taken = 1'b1;
    end
    for (int i = 0; i < int'(NCH); i++) begin
      if (rst && bus.ce && state_q[i] == IDLE && bus.start_pulse[i]) begin
        if (EXCL && taken) begin
          reject_c[i] = 1'b1;
        end else begin
          accept_c[i] = 1'b1;
          taken       = 1'b1;
        end
      end
    end
  end

  // Window level: ACTIVE, or an accepted start this cycle (covers one-cycle windows).
  always_comb begin : p_exec
    exec_c = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      exec_c[i] = (state_q[i] == ACTIVE) || accept_c[i];
    end
  end

  // Per-channel next state. Flags are cleared first so a same-cycle error wins.
  always_comb begin : p_next
    ovf_d = ovf_q & ~bus.err_clr;
    unf_d = unf_q & ~bus.err_clr;
    tmo_d = tmo_q & ~bus.err_clr;
    cfl_d = cfl_q & ~bus.err_clr;
    for (int i = 0; i < int'(NCH); i++) begin
      state_d[i] = state_q[i];
      depth_d[i] = depth_q[i];
      wdog_d[i]  = wdog_q[i];
      if (!bus.ce) begin
        state_d[i] = IDLE;
        depth_d[i] = '0;
        wdog_d[i]  = '0;
      end else begin
        unique case (state_q[i])
          IDLE: begin
            if (accept_c[i]) begin
              // start+end together is a one-cycle window; nothing to remember
              if (!bus.end_pulse[i]) begin
                state_d[i] = ACTIVE;
                depth_d[i] = DEPTH_W'(1);
                wdog_d[i]  = '0;
              end
            end else if (reject_c[i]) begin
              cfl_d[i] = 1'b1;
            end else if (bus.end_pulse[i]) begin
              unf_d[i] = 1'b1;
            end
          end
          ACTIVE: begin
            if (bus.start_pulse[i] && bus.end_pulse[i]) begin
              wdog_d[i] = '0;
            end else if (bus.start_pulse[i]) begin
              wdog_d[i] = '0;
              if (depth_q[i] == DEPTH_MAX) begin
                ovf_d[i]   = 1'b1;
                state_d[i] = FAULT;
                depth_d[i] = '0;
              end else begin
                depth_d[i] = depth_q[i] + DEPTH_W'(1);
              end
            end else if (bus.end_pulse[i]) begin
              wdog_d[i] = '0;
              if (depth_q[i] == DEPTH_W'(1)) begin
                state_d[i] = IDLE;
                depth_d[i] = '0;
              end else begin
                depth_d[i] = depth_q[i] - DEPTH_W'(1);
              end
            end else if (tmo_on_c) begin
              // trap on the increment that would reach the limit
              if (wdog_q[i] == bus.tmo_limit - TMO_W'(1)) begin
                tmo_d[i]   = 1'b1;
                state_d[i] = FAULT;
                depth_d[i] = '0;
                wdog_d[i]  = '0;
              end else begin
                wdog_d[i] = wdog_q[i] + TMO_W'(1);
              end
            end
          end
          FAULT: begin
            depth_d[i] = '0;
            wdog_d[i]  = '0;
            if (bus.err_clr[i]) state_d[i] = IDLE;
          end
          default: begin
            state_d[i] = IDLE;
            depth_d[i] = '0;
            wdog_d[i]  = '0;
          end
        endcase
      end
    end
  end

  // State and flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NCH); i++) begin
        state_q[i] <= IDLE;
        depth_q[i] <= '0;
        wdog_q[i]  <= '0;
      end
      ovf_q <= '0;
      unf_q <= '0;
      tmo_q <= '0;
      cfl_q <= '0;
    end else begin
      for (int i = 0; i < int'(NCH); i++) begin
        state_q[i] <= state_d[i];
        depth_q[i] <= depth_d[i];
        wdog_q[i]  <= wdog_d[i];
      end
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      tmo_q <= tmo_d;
      cfl_q <= cfl_d;
    end
  end

  // Lowest-index open window wins active_id.
  always_comb begin : p_id
    bus.active_id = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (exec_c[i]) bus.active_id = ID_W'(i);
    end
  end

  always_comb begin : p_depth
    bus.nest_depth = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      bus.nest_depth[i*DEPTH_W +: DEPTH_W] = depth_q[i];
    end
  end

  assign bus.secure_exec = exec_c;
  assign bus.secure_any  = |exec_c;
  assign bus.err_ovf     = ovf_q;
  assign bus.err_unf     = unf_q;
  assign bus.err_tmo     = tmo_q;
  assign bus.err_cfl     = EXCL ? cfl_q : '0;

endmodule

// File: tb/tb_or1200_cypherdb_secwin.sv
// Bench for or1200_cypherdb_secwin (NCH=4, DEPTH_W=3, TMO_W=16, EXCL=1).
// Inputs change 1ns after posedge; outputs are sampled at the following negedge.
module tb_or1200_cypherdb_secwin;
  localparam int unsigned NCH     = 4;
  localparam int unsigned DEPTH_W = 3;
  localparam int unsigned TMO_W   = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  or1200_cypherdb_secwin_if #(.NCH(NCH), .DEPTH_W(DEPTH_W), .TMO_W(TMO_W)) bus ();

  or1200_cypherdb_secwin #(
    .NCH(NCH), .DEPTH_W(DEPTH_W), .TMO_W(TMO_W), .EXCL(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [3:0]  exec;
    logic [1:0]  id;
    logic [11:0] depth;
    logic [3:0]  ovf;
    logic [3:0]  unf;
    logic [3:0]  tmo;
    logic [3:0]  cfl;
  } exp_t;

  typedef struct {
    logic       ce;
    logic [3:0] st;
    logic [3:0] en;
    logic [3:0] clr;
    exp_t       e;
    string      tag;
  } vec_t;

  int    checks   = 0;
  int    failures = 0;
  exp_t  exp_q [$];
  string tag_q [$];
  vec_t  tbl   [$];

  function automatic logic [11:0] dp(int d0, int d1, int d2, int d3);
    return {3'(d3), 3'(d2), 3'(d1), 3'(d0)};
  endfunction

  function automatic exp_t mk(logic [3:0] exec, logic [1:0] id, logic [11:0] depth,
                              logic [3:0] ovf, logic [3:0] unf, logic [3:0] tmo,
                              logic [3:0] cfl);
    exp_t e;
    e.exec = exec; e.id = id; e.depth = depth;
    e.ovf = ovf; e.unf = unf; e.tmo = tmo; e.cfl = cfl;
    return e;
  endfunction

  function automatic void add(logic ce, logic [3:0] st, logic [3:0] en, logic [3:0] clr,
                              exp_t e, string tag);
    vec_t v;
    v.ce = ce; v.st = st; v.en = en; v.clr = clr; v.e = e; v.tag = tag;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compare(input exp_t e, input string tag);
    chk({tag, " secure_exec"}, 32'(bus.secure_exec), 32'(e.exec));
    chk({tag, " secure_any"},  32'(bus.secure_any),  32'(|e.exec));
    chk({tag, " active_id"},   32'(bus.active_id),   32'(e.id));
    chk({tag, " nest_depth"},  32'(bus.nest_depth),  32'(e.depth));
    chk({tag, " err_ovf"},     32'(bus.err_ovf),     32'(e.ovf));
    chk({tag, " err_unf"},     32'(bus.err_unf),     32'(e.unf));
    chk({tag, " err_tmo"},     32'(bus.err_tmo),     32'(e.tmo));
    chk({tag, " err_cfl"},     32'(bus.err_cfl),     32'(e.cfl));
  endtask

  // Drive one cycle, queue its expectation, check it at the negedge.
  task automatic cyc(input logic ce, input logic [3:0] st, input logic [3:0] en,
                     input logic [3:0] clr, input exp_t e, input string tag);
    exp_t  x;
    string t;
    bus.ce = ce; bus.start_pulse = st; bus.end_pulse = en; bus.err_clr = clr;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    x = exp_q.pop_front();
    t = tag_q.pop_front();
    compare(x, t);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    exp_t z;
    z = mk(4'h0, 2'd0, 12'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    // Nested windows on ch1
    add(1, 4'b0010, 4'b0000, 4'b0000, mk(4'b0010, 2'd1, dp(0,0,0,0), 0, 0, 0, 0), "t2 start1");
    add(1, 4'b0010, 4'b0000, 4'b0000, mk(4'b0010, 2'd1, dp(0,1,0,0), 0, 0, 0, 0), "t2 start2");
    add(1, 4'b0010, 4'b0000, 4'b0000, mk(4'b0010, 2'd1, dp(0,2,0,0), 0, 0, 0, 0), "t2 start3");
    add(1, 4'b0000, 4'b0010, 4'b0000, mk(4'b0010, 2'd1, dp(0,3,0,0), 0, 0, 0, 0), "t2 end1");
    add(1, 4'b0000, 4'b0010, 4'b0000, mk(4'b0010, 2'd1, dp(0,2,0,0), 0, 0, 0, 0), "t2 end2");
    add(1, 4'b0000, 4'b0010, 4'b0000, mk(4'b0010, 2'd1, dp(0,1,0,0), 0, 0, 0, 0), "t2 end3");
    add(1, 4'b0000, 4'b0000, 4'b0000, mk(4'b0000, 2'd0, dp(0,0,0,0), 0, 0, 0, 0), "t2 closed");
    // Exclusion
    add(1, 4'b1001, 4'b0000, 4'b0000, mk(4'b0001, 2'd0, dp(0,0,0,0), 0, 0, 0, 4'b0000), "t4 dual start");
    add(1, 4'b1000, 4'b0000, 4'b0000, mk(4'b0001, 2'd0, dp(1,0,0,0), 0, 0, 0, 4'b1000), "t4 ch3 blocked");
    add(1, 4'b0000, 4'b0001, 4'b0000, mk(4'b0001, 2'd0, dp(1,0,0,0), 0, 0, 0, 4'b1000), "t4 ch0 end");
    add(1, 4'b0110, 4'b0000, 4'b0000, mk(4'b0010, 2'd1, dp(0,0,0,0), 0, 0, 0, 4'b1000), "t4 ch1 ch2 start");
    add(1, 4'b0000, 4'b0010, 4'b0000, mk(4'b0010, 2'd1, dp(0,1,0,0), 0, 0, 0, 4'b1100), "t4 ch1 end");
    add(1, 4'b0000, 4'b0000, 4'b1100, mk(4'b0000, 2'd0, dp(0,0,0,0), 0, 0, 0, 4'b1100), "t4 clr");
    add(1, 4'b0000, 4'b0000, 4'b0000, mk(4'b0000, 2'd0, dp(0,0,0,0), 0, 0, 0, 4'b0000), "t4 cleared");
    // Underflow, clear priority, ce abort
    add(1, 4'b0000, 4'b0010, 4'b0000, mk(4'b0000, 2'd0, dp(0,0,0,0), 0, 4'b0000, 0, 0), "t5 unf end");
    add(1, 4'b0000, 4'b0000, 4'b0010, mk(4'b0000, 2'd0, dp(0,0,0,0), 0, 4'b0010, 0, 0), "t5 unf clr");
    add(1, 4'b0000, 4'b0000, 4'b0000, mk(4'b0000, 2'd0, dp(0,0,0,0), 0, 4'b0000, 0, 0), "t5 unf gone");
    add(1, 4'b0000, 4'b0010, 4'b0010, mk(4'b0000, 2'd0, dp(0,0,0,0), 0, 4'b0000, 0, 0), "t5 err+clr");
    add(1, 4'b0000, 4'b0000, 4'b0000, mk(4'b0000, 2'd0, dp(0,0,0,0), 0, 4'b0010, 0, 0), "t5 err wins");
    add(1, 4'b0000, 4'b0001, 4'b0000, mk(4'b0000, 2'd0, dp(0,0,0,0), 0, 4'b0010, 0, 0), "t5 unf ch0");
    add(1, 4'b0001, 4'b0000, 4'b0000, mk(4'b0001, 2'd0, dp(0,0,0,0), 0, 4'b0011, 0, 0), "t5 ch0 start");
    add(1, 4'b0000, 4'b0000, 4'b0001, mk(4'b0001, 2'd0, dp(1,0,0,0), 0, 4'b0011, 0, 0), "t5 clr active");
    add(0, 4'b0000, 4'b0000, 4'b0000, mk(4'b0001, 2'd0, dp(1,0,0,0), 0, 4'b0010, 0, 0), "t5 ce drop");
    add(0, 4'b0001, 4'b0000, 4'b0000, mk(4'b0000, 2'd0, dp(0,0,0,0), 0, 4'b0010, 0, 0), "t5 ce low start");
    add(0, 4'b0000, 4'b0000, 4'b0010, mk(4'b0000, 2'd0, dp(0,0,0,0), 0, 4'b0010, 0, 0), "t5 clr ce low");
    add(1, 4'b0000, 4'b0000, 4'b0000, mk(4'b0000, 2'd0, dp(0,0,0,0), 0, 4'b0000, 0, 0), "t5 clr done");

    bus.ce = 1'b1; bus.start_pulse = '0; bus.end_pulse = '0; bus.err_clr = '0;
    bus.tmo_en = 1'b1; bus.tmo_limit = '0;

    // Reset state
    @(negedge clk);
    compare(z, "reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // T1: single window on ch0, watchdog disabled by limit 0
    cyc(1, 4'b0001, 4'b0000, 4'b0000, mk(4'b0001, 2'd0, dp(0,0,0,0), 0, 0, 0, 0), "t1 start");
    for (int k = 2; k <= 9; k++)
      cyc(1, 4'b0000, 4'b0000, 4'b0000, mk(4'b0001, 2'd0, dp(1,0,0,0), 0, 0, 0, 0), "t1 open");
    cyc(1, 4'b0000, 4'b0001, 4'b0000, mk(4'b0001, 2'd0, dp(1,0,0,0), 0, 0, 0, 0), "t1 end");
    cyc(1, 4'b0000, 4'b0000, 4'b0000, z, "t1 closed");

    // Table vectors
    foreach (tbl[i]) cyc(tbl[i].ce, tbl[i].st, tbl[i].en, tbl[i].clr, tbl[i].e, tbl[i].tag);

    // Overflow on ch1: eight starts, the eighth at depth 7 faults
    for (int k = 0; k < 8; k++)
      cyc(1, 4'b0010, 4'b0000, 4'b0000, mk(4'b0010, 2'd1, dp(0,k,0,0), 0, 0, 0, 0), "t2 deep");
    cyc(1, 4'b0000, 4'b0000, 4'b0000, mk(4'b0000, 2'd0, dp(0,0,0,0), 4'b0010, 0, 0, 0), "t2 ovf fault");
    cyc(1, 4'b0010, 4'b0000, 4'b0000, mk(4'b0000, 2'd0, dp(0,0,0,0), 4'b0010, 0, 0, 0), "t2 fault start");
    cyc(1, 4'b0000, 4'b0010, 4'b0000, mk(4'b0000, 2'd0, dp(0,0,0,0), 4'b0010, 0, 0, 0), "t2 fault end");
    cyc(1, 4'b0000, 4'b0000, 4'b0010, mk(4'b0000, 2'd0, dp(0,0,0,0), 4'b0010, 0, 0, 0), "t2 fault clr");
    cyc(1, 4'b0010, 4'b0000, 4'b0000, mk(4'b0010, 2'd1, dp(0,0,0,0), 0, 0, 0, 0), "t2 restart");
    cyc(1, 4'b0000, 4'b0010, 4'b0000, mk(4'b0010, 2'd1, dp(0,1,0,0), 0, 0, 0, 0), "t2 reclose");
    cyc(1, 4'b0000, 4'b0000, 4'b0000, z, "t2 idle");

    // T3: watchdog limit 5 on ch2, nested start restarts the count
    bus.tmo_limit = 16'd5;
    cyc(1, 4'b0100, 4'b0000, 4'b0000, mk(4'b0100, 2'd2, dp(0,0,0,0), 0, 0, 0, 0), "t3 start");
    for (int k = 1; k <= 3; k++)
      cyc(1, 4'b0000, 4'b0000, 4'b0000, mk(4'b0100, 2'd2, dp(0,0,1,0), 0, 0, 0, 0), "t3 count");
    cyc(1, 4'b0100, 4'b0000, 4'b0000, mk(4'b0100, 2'd2, dp(0,0,1,0), 0, 0, 0, 0), "t3 nest");
    for (int k = 5; k <= 9; k++)
      cyc(1, 4'b0000, 4'b0000, 4'b0000, mk(4'b0100, 2'd2, dp(0,0,2,0), 0, 0, 0, 0), "t3 count2");
    cyc(1, 4'b0000, 4'b0000, 4'b0000, mk(4'b0000, 2'd0, dp(0,0,0,0), 0, 0, 4'b0100, 0), "t3 timeout");
    cyc(1, 4'b0000, 4'b0100, 4'b0000, mk(4'b0000, 2'd0, dp(0,0,0,0), 0, 0, 4'b0100, 0), "t3 late end");
    cyc(1, 4'b0000, 4'b0000, 4'b0100, mk(4'b0000, 2'd0, dp(0,0,0,0), 0, 0, 4'b0100, 0), "t3 clr");
    cyc(1, 4'b0000, 4'b0000, 4'b0000, z, "t3 cleared");
    bus.tmo_limit = '0;

    // T6: asynchronous reset mid-window with an error flag set
    cyc(1, 4'b0001, 4'b0000, 4'b0000, mk(4'b0001, 2'd0, dp(0,0,0,0), 0, 0, 0, 0), "t6 start");
    cyc(1, 4'b0000, 4'b0010, 4'b0000, mk(4'b0001, 2'd0, dp(1,0,0,0), 0, 0, 0, 0), "t6 unf");
    bus.start_pulse = '0; bus.end_pulse = '0; bus.err_clr = '0;
    chk("t6 pre-reset unf", 32'(bus.err_unf), 32'(4'b0010));
    #2 rst = 1'b0;
    #1 compare(z, "t6 async reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc(1, 4'b0100, 4'b0100, 4'b0000, mk(4'b0100, 2'd2, dp(0,0,0,0), 0, 0, 0, 0), "t6 one-cycle");
    cyc(1, 4'b0000, 4'b0000, 4'b0000, z, "t6 after pulse");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
